mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; number of add/shift iterations per multiply; legal range 2..16.
REQ-002 Port: Mult_Ctrl_Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: Mult_Ctrl_Reset_n  input  1  reset, synchronous, active-low.
REQ-004 Port: Mult_Ctrl_Start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: Mult_Ctrl_Abort  input  1  cancel an operation in progress; sampled in LOAD, ADD and SHIFT.
REQ-006 Port: Mult_Ctrl_Q_LSB  input  1  current multiplier LSB, driven by the Q register stage.
REQ-007 Port: Mult_Ctrl_Load  output  1  load operands into the Q, multiplicand and accumulator registers; the accumulator clears on this load.
REQ-008 Port: Mult_Ctrl_Add  output  1  accumulator += multiplicand this cycle.
REQ-009 Port: Mult_Ctrl_Shift  output  1  shift the accumulator:Q pair right one bit this cycle.
REQ-010 Port: Mult_Ctrl_Busy  output  1  high in all states except IDLE.
REQ-011 Port: Mult_Ctrl_Done  output  1  one-cycle pulse; the product is valid in the datapath.

Function
REQ-012 FSM states: IDLE, LOAD, ADD, SHIFT, DONE; one state register; the block SHALL never enter any other state.
REQ-013 Iteration counter: ceil(log2(WIDTH+1)) bits; set to WIDTH in LOAD; decremented by 1 in each SHIFT cycle.
REQ-014 Transition IDLE->LOAD when Start=1; otherwise stay in IDLE.
REQ-015 Transition LOAD->ADD unconditionally, unless Abort=1.
REQ-016 Transition ADD->SHIFT unconditionally, unless Abort=1.
REQ-017 Transition SHIFT->ADD when the counter value before decrement is >1; SHIFT->DONE when it is 1; Abort=1 overrides both.
REQ-018 Transition DONE->IDLE unconditionally; Abort and Start are ignored in DONE.
REQ-019 Abort=1 in LOAD, ADD or SHIFT: next state IDLE; no Done pulse; the counter is cleared to 0.
REQ-020 Load=1 only in LOAD; Shift=1 only in SHIFT; Done=1 only in DONE; Busy=1 in LOAD, ADD, SHIFT and DONE.
REQ-021 Add = (state==ADD) AND Q_LSB; this is the only output with a combinational input dependency.
REQ-022 Add, Shift and Load SHALL never be high simultaneously in the same cycle.
REQ-023 Latency with Start sampled at edge N: Load high in cycle N+1; ADD/SHIFT alternate over cycles N+2..N+2*WIDTH+1; Done high in cycle N+2*WIDTH+2; Busy falls in cycle N+2*WIDTH+3.
REQ-024 There SHALL be exactly WIDTH ADD cycles and WIDTH SHIFT cycles per non-aborted operation.
REQ-025 Start asserted while Busy=1: ignored; the operation in progress is unaffected.
REQ-026 Start held continuously high: back-to-back operations, with exactly one IDLE cycle between Done and the next Load.
REQ-027 Abort and Start both high in IDLE: Start wins (Abort is not sampled in IDLE).

Reset
REQ-028 Reset_n=0 at a clock edge: state=IDLE and counter=0, regardless of state; this overrides Start and Abort.
REQ-029 After reset: Load=0, Add=0, Shift=0, Busy=0, Done=0.
REQ-030 Reset mid-operation: no Done pulse for the interrupted operation; the next Start begins a full new operation.

Verification
REQ-031 WIDTH=4, Start pulse at edge 0, Q_LSB sequence 1,1,0,1 across the ADD cycles -> Load in cycle 1; Add high in cycles 2, 4 and 8; Shift high in cycles 3, 5, 7 and 9; Done in cycle 10; Busy low in cycle 11.
REQ-032 Q_LSB=0 throughout -> Add never asserts; Shift count=4; Done in cycle 10.
REQ-033 Start held high for 30 cycles -> Load in cycles 1, 12 and 23; one Done per run, in cycles 10 and 21.
REQ-034 Reset_n=0 in cycle 5 of a run -> from cycle 6: all outputs 0 and state IDLE; no Done; a new Start yields a full 10-cycle run.
REQ-035 Abort=1 in the second SHIFT cycle (cycle 5) -> IDLE in cycle 6; Busy=0; no Done; a Start pulse in cycle 3 is ignored.
REQ-036 Assertion check for all runs: Add, Shift and Load are mutually exclusive, and Done width is 1 cycle.

Source files
------------

// File: rtl/mult_ctrl.sv
// Sequencing controller for a shift-and-add multiplier: it issues Load, then
// alternating Add/Shift over WIDTH iterations, then a one-cycle Done pulse.
module mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic Mult_Ctrl_Clock,
  input  logic Mult_Ctrl_Reset_n,
  input  logic Mult_Ctrl_Start,
  input  logic Mult_Ctrl_Abort,
  input  logic Mult_Ctrl_Q_LSB,
  output logic Mult_Ctrl_Load,
  output logic Mult_Ctrl_Add,
  output logic Mult_Ctrl_Shift,
  output logic Mult_Ctrl_Busy,
  output logic Mult_Ctrl_Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge Mult_Ctrl_Clock) begin
    if (!Mult_Ctrl_Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Abort only matters while the datapath is being driven; DONE always retires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Mult_Ctrl_Start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (Mult_Ctrl_Abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_ADD;
          cnt_d   = CNT_INIT;
        end
      end
      S_ADD: begin
        if (Mult_Ctrl_Abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (Mult_Ctrl_Abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? S_DONE : S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    Mult_Ctrl_Load  = (state_q == S_LOAD);
    Mult_Ctrl_Add   = (state_q == S_ADD) && Mult_Ctrl_Q_LSB;
    Mult_Ctrl_Shift = (state_q == S_SHIFT);
    Mult_Ctrl_Done  = (state_q == S_DONE);
    Mult_Ctrl_Busy  = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Randomized and directed bench for mult_ctrl against a run-position model:
// each run is tracked as an offset from the cycle its Start was accepted.
module tb_mult_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n, start, abort, qlsb;
  logic load, add, shift, busy, done;

  int checks = 0;
  int errors = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .Mult_Ctrl_Clock  (clk),
    .Mult_Ctrl_Reset_n(rst_n),
    .Mult_Ctrl_Start  (start),
    .Mult_Ctrl_Abort  (abort),
    .Mult_Ctrl_Q_LSB  (qlsb),
    .Mult_Ctrl_Load   (load),
    .Mult_Ctrl_Add    (add),
    .Mult_Ctrl_Shift  (shift),
    .Mult_Ctrl_Busy   (busy),
    .Mult_Ctrl_Done   (done)
  );

  always #5 clk = ~clk;

  // Model: pos = -1 when idle, otherwise the cycle offset within the run (1 = Load).
  int pos = -1;
  int cyc = 0;
  int load_mask, add_mask, shift_mask, done_mask, busy_mask;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clr();
    cyc = 0;
    load_mask = 0; add_mask = 0; shift_mask = 0; done_mask = 0; busy_mask = 0;
  endtask

  task automatic step(input logic s, input logic a, input logic r, input logic q);
    int e_load, e_add, e_shift, e_done, e_busy;
    @(negedge clk);
    start = s; abort = a; rst_n = r; qlsb = q;
    #1;
    e_load  = int'(pos == 1);
    e_add   = int'(pos >= 2 && pos <= 2*W+1 && (pos % 2) == 0 && q);
    e_shift = int'(pos >= 3 && pos <= 2*W+1 && (pos % 2) == 1);
    e_done  = int'(pos == 2*W+2);
    e_busy  = int'(pos != -1);
    chk("load",  int'(load),  e_load);
    chk("add",   int'(add),   e_add);
    chk("shift", int'(shift), e_shift);
    chk("done",  int'(done),  e_done);
    chk("busy",  int'(busy),  e_busy);
    chk("excl",  int'(load) + int'(add) + int'(shift) <= 1 ? 1 : 0, 1);
    chk("done_width", int'(done && prev_done), 0);
    prev_done = done;
    if (cyc < 32) begin
      if (load)  load_mask  |= (32'd1 << cyc);
      if (add)   add_mask   |= (32'd1 << cyc);
      if (shift) shift_mask |= (32'd1 << cyc);
      if (done)  done_mask  |= (32'd1 << cyc);
      if (busy)  busy_mask  |= (32'd1 << cyc);
    end
    @(posedge clk);
    if (!r)                pos = -1;
    else if (pos == -1)    pos = s ? 1 : -1;
    else if (pos == 2*W+2) pos = -1;
    else if (a)            pos = -1;
    else                   pos++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; qlsb = 1'b0;
    repeat (2) @(posedge clk);
    pos = -1;

    // Reset state, with Start/Abort pressed while reset is active.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Q_LSB 1,1,0,1 across the ADD cycles, 1 in every other cycle.
    clr();
    for (int i = 0; i < 13; i++)
      step(i == 0, 1'b0, 1'b1, (i % 2 == 1) || i == 2 || i == 4 || i == 8);
    chk("r31_load",  load_mask,  32'h2);
    chk("r31_add",   add_mask,   32'h114);
    chk("r31_shift", shift_mask, 32'h2A8);
    chk("r31_done",  done_mask,  32'h400);
    chk("r31_busy",  busy_mask,  32'h7FE);

    // Q_LSB held low.
    clr();
    for (int i = 0; i < 13; i++) step(i == 0, 1'b0, 1'b1, 1'b0);
    chk("r32_add",   add_mask,   32'h0);
    chk("r32_shift", shift_mask, 32'h2A8);
    chk("r32_done",  done_mask,  32'h400);

    // Start held high for 30 cycles: back-to-back runs.
    clr();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    idle(14);
    chk("r33_load", load_mask, 32'h0080_1002);
    chk("r33_done", done_mask, 32'h0020_0400);

    // Reset asserted in cycle 5 of a run, then a fresh run.
    clr();
    for (int i = 0; i < 10; i++) step(i == 0, 1'b0, i != 5, 1'b1);
    chk("r34_done", done_mask, 32'h0);
    chk("r34_busy", busy_mask, 32'h3E);
    clr();
    for (int i = 0; i < 13; i++) step(i == 0, 1'b0, 1'b1, 1'b1);
    chk("r34_rerun_done", done_mask, 32'h400);
    chk("r34_rerun_busy", busy_mask, 32'h7FE);

    // Abort in the second SHIFT cycle; a Start in cycle 3 is ignored.
    clr();
    for (int i = 0; i < 12; i++) step(i == 0 || i == 3, i == 5, 1'b1, 1'b1);
    chk("r35_load", load_mask, 32'h2);
    chk("r35_busy", busy_mask, 32'h3E);
    chk("r35_done", done_mask, 32'h0);

    // Abort together with Start while idle: Start must win.
    clr();
    for (int i = 0; i < 13; i++) step(i == 0, 1'b1 && i == 0, 1'b1, 1'b0);
    chk("r27_done", done_mask, 32'h400);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
